// File: rtl/seq_count_ctrl_pkg.sv
// Shared types and helpers for the cascaded counter controller.
// Holds the FSM state encoding, the default terminal-value helper and the
// binary-to-Gray conversion used on the CNT output path.
package seq_count_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        WRAP = 2'd3
    } state_t;

    localparam int DEF_CNT_W = 4;

    // Largest value representable in w bits; used as the default wrap point.
    function automatic int max_term(input int w);
        return (1 << w) - 1;
    endfunction

    // Fixed 32-bit form; callers truncate the result to their channel width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/seq_count_cell.sv
// One CNT_W-bit counter channel that wraps term->0 on increment.
// Latency: value updates on the edge after inc_i/clr_i; at_term_o is a decode of the register.
// Backpressure: none; clr_i overrides inc_i.
// Ports: clk_i, rst_ni (async, active low), clr_i, inc_i, term_i -> value_o, at_term_o.
module seq_count_cell #(
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] term_i,
    output logic [CNT_W-1:0] value_o,
    output logic             at_term_o
);

    logic [CNT_W-1:0] value_q;
    logic [CNT_W-1:0] value_d;

    assign at_term_o = (value_q == term_i);
    assign value_o   = value_q;

    always_comb begin
        value_d = value_q;
        if (clr_i) begin
            value_d = '0;
        end else if (inc_i) begin
            value_d = at_term_o ? '0 : value_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/seq_count_ctrl.sv
// NCH cascaded counter channels under an IDLE/RUN/HOLD/WRAP FSM, with a serial DIN history and pattern freeze.
// Latency: all outputs are flops or decode of flops; CNT/STATE update one edge after inputs.
// Backpressure: EN low or a pattern MATCH freezes counting (HOLD); CLR forces IDLE synchronously.
// Ports: CK, RN (async, active low), CLR, EN, DIN -> CNT (ch0 in LSBs), STATE, WRAP_P, MATCH.
// Build option: define GRAY_OUT_EN to present every CNT channel Gray-coded.
module seq_count_ctrl
    import seq_count_ctrl_pkg::*;
#(
    parameter int              CNT_W   = DEF_CNT_W,
    parameter int              NCH     = 2,
    parameter int              TERM    = max_term(CNT_W),
    parameter int              SR_W    = 4,
    parameter logic [SR_W-1:0] PATTERN = SR_W'(4'b1011)
) (
    input  logic                 CK,
    input  logic                 RN,
    input  logic                 CLR,
    input  logic                 EN,
    input  logic                 DIN,
    output logic [NCH*CNT_W-1:0] CNT,
    output logic [1:0]           STATE,
    output logic                 WRAP_P,
    output logic                 MATCH
);

    state_t            state_q, state_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic              run_inc;
    logic              cnt_clr;
    logic [NCH-1:0]    at_term;
    logic [NCH-1:0]    inc;
    logic [CNT_W-1:0]  val [NCH];
    logic              all_term;

    assign MATCH    = (sr_q == PATTERN);
    assign all_term = &at_term;
    assign STATE    = state_q;
    assign WRAP_P   = (state_q == WRAP);

    // History shifts in every state; only CLR interrupts it.
    assign sr_d = CLR ? '0 : {sr_q[SR_W-2:0], DIN};

    always_comb begin
        state_d = state_q;
        run_inc = 1'b0;
        cnt_clr = 1'b0;
        if (CLR) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_clr = 1'b1;
                    if (EN) state_d = RUN;
                end
                RUN: begin
                    if (MATCH || !EN) begin
                        state_d = HOLD;
                    end else if (all_term) begin
                        state_d = WRAP;
                        cnt_clr = 1'b1;
                    end else begin
                        run_inc = 1'b1;
                    end
                end
                HOLD: begin
                    if (EN && !MATCH) state_d = RUN;
                end
                WRAP: begin
                    cnt_clr = 1'b1;
                    state_d = EN ? RUN : IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= IDLE;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
        end
    end

    // Ripple carry: channel k steps only when every lower channel sits at TERM.
    assign inc[0] = run_inc;
    for (genvar k = 1; k < NCH; k++) begin : g_carry
        assign inc[k] = inc[k-1] & at_term[k-1];
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        seq_count_cell #(.CNT_W(CNT_W)) u_cell (
            .clk_i     (CK),
            .rst_ni    (RN),
            .clr_i     (cnt_clr),
            .inc_i     (inc[k]),
            .term_i    (CNT_W'(TERM)),
            .value_o   (val[k]),
            .at_term_o (at_term[k])
        );
`ifdef GRAY_OUT_EN
        assign CNT[k*CNT_W +: CNT_W] = CNT_W'(bin2gray(32'(val[k])));
`else
        assign CNT[k*CNT_W +: CNT_W] = val[k];
`endif
    end

endmodule

// File: tb/tb_seq_count_ctrl.sv
module tb_seq_count_ctrl;

    logic       CK = 1'b0;
    logic       RN, CLR, EN, DIN;
    logic [7:0] CNT;
    logic [1:0] STATE;
    logic       WRAP_P, MATCH;

    int n_cmp = 0;
    int n_err = 0;

    seq_count_ctrl dut (
        .CK(CK), .RN(RN), .CLR(CLR), .EN(EN), .DIN(DIN),
        .CNT(CNT), .STATE(STATE), .WRAP_P(WRAP_P), .MATCH(MATCH)
    );

    always #5 CK = ~CK;

    // Expected CNT presentation for a given binary channel pair.
    function automatic logic [7:0] exp_cnt(input logic [7:0] b);
`ifdef GRAY_OUT_EN
        logic [3:0] lo, hi;
        lo = b[3:0];
        hi = b[7:4];
        return {hi ^ (hi >> 1), lo ^ (lo >> 1)};
`else
        return b;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        RN = 1'b0; CLR = 1'b0; EN = 1'b0; DIN = 1'b0;
        #2;
        check("rst_cnt",   32'(CNT),    32'(exp_cnt(8'h00)));
        check("rst_state", 32'(STATE),  32'd0);
        check("rst_wrap",  32'(WRAP_P), 32'd0);
        check("rst_match", 32'(MATCH),  32'd0);
        step();
        RN = 1'b1;
        step();
        check("idle_hold", 32'(STATE), 32'd0);

        // Full count: entry edge, then 255 increments to FF, then WRAP, then RUN.
        EN = 1'b1;
        step();
        check("run_entry_state", 32'(STATE), 32'd1);
        check("run_entry_cnt",   32'(CNT),   32'(exp_cnt(8'h00)));
        steps(16);
        check("carry_10", 32'(CNT), 32'(exp_cnt(8'h10)));
        steps(239);
        check("cnt_ff",     32'(CNT),   32'(exp_cnt(8'hFF)));
        check("ff_state",   32'(STATE), 32'd1);
        step();
        check("wrap_state", 32'(STATE),  32'd3);
        check("wrap_p",     32'(WRAP_P), 32'd1);
        check("wrap_cnt",   32'(CNT),    32'(exp_cnt(8'h00)));
        step();
        check("post_wrap_state", 32'(STATE),  32'd1);
        check("post_wrap_p",     32'(WRAP_P), 32'd0);
        check("post_wrap_cnt",   32'(CNT),    32'(exp_cnt(8'h00)));

        // Hold / resume across the ch0->ch1 carry.
        steps(15);
        check("cnt_0f", 32'(CNT), 32'(exp_cnt(8'h0F)));
        EN = 1'b0;
        step();
        check("hold_state", 32'(STATE), 32'd2);
        check("hold_cnt",   32'(CNT),   32'(exp_cnt(8'h0F)));
        step();
        check("hold_stay",  32'(STATE), 32'd2);
        EN = 1'b1;
        step();
        check("resume_state", 32'(STATE), 32'd1);
        check("resume_cnt",   32'(CNT),   32'(exp_cnt(8'h0F)));
        step();
        check("resume_carry", 32'(CNT), 32'(exp_cnt(8'h10)));

        // Pattern 1011 freezes counting.
        DIN = 1'b1; step();
        DIN = 1'b0; step();
        DIN = 1'b1; step();
        check("pre_match", 32'(MATCH), 32'd0);
        DIN = 1'b1; step();
        check("match_hi",    32'(MATCH), 32'd1);
        check("match_cnt",   32'(CNT),   32'(exp_cnt(8'h14)));
        DIN = 1'b0; step();
        check("match_hold",  32'(STATE), 32'd2);
        check("match_noinc", 32'(CNT),   32'(exp_cnt(8'h14)));
        check("match_lo",    32'(MATCH), 32'd0);
        step();
        check("match_resume", 32'(STATE), 32'd1);
        check("match_res_cnt", 32'(CNT),  32'(exp_cnt(8'h14)));
        step();
        check("match_res_inc", 32'(CNT), 32'(exp_cnt(8'h15)));

        // Count to A5, loading SR with x101 on the last three edges.
        steps(141);
        DIN = 1'b1; step();
        DIN = 1'b0; step();
        DIN = 1'b1; step();
        check("cnt_a5", 32'(CNT), 32'(exp_cnt(8'hA5)));
        // CLR beats EN; a DIN=1 here would complete 1011 if SR were not cleared.
        CLR = 1'b1; EN = 1'b1; DIN = 1'b1;
        step();
        check("clr_cnt",   32'(CNT),   32'(exp_cnt(8'h00)));
        check("clr_state", 32'(STATE), 32'd0);
        check("clr_match", 32'(MATCH), 32'd0);
        CLR = 1'b0; DIN = 1'b0;
        step();
        check("clr_run", 32'(STATE), 32'd1);
        check("clr_run_cnt", 32'(CNT), 32'(exp_cnt(8'h00)));
        step();
        check("clr_inc", 32'(CNT), 32'(exp_cnt(8'h01)));

        // Asynchronous reset mid-RUN at 37.
        steps(54);
        check("cnt_37", 32'(CNT), 32'(exp_cnt(8'h37)));
        #2;
        RN = 1'b0;
        #1;
        check("arst_cnt",   32'(CNT),    32'(exp_cnt(8'h00)));
        check("arst_state", 32'(STATE),  32'd0);
        check("arst_wrap",  32'(WRAP_P), 32'd0);
        step();
        RN = 1'b1; EN = 1'b0;
        step();
        check("arst_idle", 32'(STATE), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
